dmem_responder: RTL and testbench

- Data-memory responder: the target side of the M stage's dmem request interface.
- Accepts one load/store request per transaction over a valid/ready handshake and performs byte/half/word access on an internal word array.
- Returns a response after a configurable latency, held until consumed. Read data is sign- or zero-extended per MemOp.
- Sits between the M stage (initiator) and W stage data path; replaces the single-cycle dmem model in the pipelined CPU.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_fmt.sv | 46 ++++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared MemOp codes, responder state encoding and access-format helpers for dmem_responder.
package dmem_pkg;

    localparam logic [2:0] MEMOP_W  = 3'b000;
    localparam logic [2:0] MEMOP_B  = 3'b001;
    localparam logic [2:0] MEMOP_H  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b101;
    localparam logic [2:0] MEMOP_HU = 3'b110;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Unassigned codes behave as a word access.
    function automatic logic [2:0] memop_norm(input logic [2:0] op);
        case (op)
            MEMOP_B, MEMOP_H, MEMOP_BU, MEMOP_HU: memop_norm = op;
            default:                              memop_norm = MEMOP_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic [2:0] v_op;
        v_op = memop_norm(op);
        case (v_op)
            MEMOP_H, MEMOP_HU: is_misaligned = addr_lo[0];
            MEMOP_B, MEMOP_BU: is_misaligned = 1'b0;
            default:           is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane formatter: store byte enables / replicated store word, and
// load extraction with sign or zero extension.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_raw,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [2:0]  w_op;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_op   = memop_norm(i_op);
    assign w_byte = i_raw[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

    always_comb begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
        o_rdata = i_raw;
        case (w_op)
            MEMOP_B, MEMOP_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = (w_op == MEMOP_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            end
            MEMOP_H, MEMOP_HU: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdata[15:0]}};
                o_rdata = (w_op == MEMOP_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            end
            default: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_raw;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with valid/ready request and response channels and fixed latency.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// WAIT  | request latched, latency counter running
// RESP  | response held on resp_* until resp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int   AW = $clog2(DEPTH);
    localparam int   CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic L1 = (LATENCY == 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_op;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_cur_we;
    logic [2:0]    w_cur_op;
    logic [31:0]   w_cur_addr;
    logic [31:0]   w_cur_wdata;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_ext;
    logic          w_mis;
    logic          w_commit;
    logic          w_wr_en;
    logic [31:0]   w_rsp_data;
    logic          w_unused;

    // With LATENCY==1 the commit happens on the accept edge, so the live request is used.
    assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_op    = (r_state == IDLE) ? req_op    : r_op;
    assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_idx       = w_cur_addr[AW+1:2];
    assign w_unused    = ^{w_cur_addr[31:AW+2]};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_mis = is_misaligned(w_cur_op, w_cur_addr[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    dmem_lane_fmt u_fmt (
        .i_op      (w_cur_op),
        .i_addr_lo (w_cur_addr[1:0]),
        .i_wdata   (w_cur_wdata),
        .i_raw     (r_mem[w_idx]),
        .o_be      (w_be),
        .o_wword   (w_wword),
        .o_rdata   (w_ext)
    );

    assign w_commit   = (L1 && (r_state == IDLE) && req_valid) ||
                        ((r_state == WAIT) && (r_cnt == CW'(1)));
    assign w_wr_en    = w_commit && w_cur_we && !w_mis && !rst;
    assign w_rsp_data = (w_cur_we || w_mis) ? 32'd0 : w_ext;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_op    <= MEMOP_W;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= CW'(LATENCY - 1);
                        if (L1) begin
                            r_state <= RESP;
                            r_rdata <= w_rsp_data;
                            r_err   <= w_mis;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_commit) begin
                        r_state <= RESP;
                        r_rdata <= w_rsp_data;
                        r_err   <= w_mis;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at DEPTH=1024, LATENCY=2.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction with resp_ready asserted as soon as the response appears.
    task automatic txn(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".wait_rv"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ".wait_rdy"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, ".rv"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ".done_rv"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ".done_rdata"}, resp_rdata, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_op     = MEMOP_W;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;

        #12;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        txn("sw10", 1'b1, MEMOP_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("lw10", 1'b0, MEMOP_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        txn("sb13",  1'b1, MEMOP_B,  32'h13, 32'h00000081, 32'h0, 1'b0);
        txn("lb13",  1'b0, MEMOP_B,  32'h13, 32'h0, 32'hFFFFFF81, 1'b0);
        txn("lbu13", 1'b0, MEMOP_BU, 32'h13, 32'h0, 32'h00000081, 1'b0);
        txn("sh12",  1'b1, MEMOP_H,  32'h12, 32'hFFFF8001, 32'h0, 1'b0);
        txn("lh12",  1'b0, MEMOP_H,  32'h12, 32'h0, 32'hFFFF8001, 1'b0);
        txn("lhu12", 1'b0, MEMOP_HU, 32'h12, 32'h0, 32'h00008001, 1'b0);
        txn("lbu10", 1'b0, MEMOP_BU, 32'h10, 32'h0, 32'h000000EF, 1'b0);
        txn("lbu11", 1'b0, MEMOP_BU, 32'h11, 32'h0, 32'h000000BE, 1'b0);
        txn("lh10",  1'b0, MEMOP_H,  32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);

        // Backpressure: response held for 5 cycles while a new request waits.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_op = MEMOP_W; req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h11111111;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp.rv", {31'd0, resp_valid}, 32'd1);
            chk("bp.rdata", resp_rdata, 32'h8001BEEF);
            chk("bp.rdy", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp.idle_rdy", {31'd0, req_ready}, 32'd1);
        chk("bp.idle_rv", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp.accepted", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("bp.sw_rv", {31'd0, resp_valid}, 32'd1);
        chk("bp.sw_rdata", resp_rdata, 32'h0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        txn("lw40", 1'b0, MEMOP_W, 32'h40, 32'h0, 32'h11111111, 1'b0);

        txn("sw1000", 1'b1, MEMOP_W, 32'h1000, 32'h12345678, 32'h0, 1'b0);
        txn("lw0",    1'b0, MEMOP_W, 32'h0, 32'h0, 32'h12345678, 1'b0);
        txn("op7",    1'b0, 3'b111,  32'h0, 32'h0, 32'h12345678, 1'b0);

        // Reset during WAIT discards the uncommitted store.
        txn("sw20", 1'b1, MEMOP_W, 32'h20, 32'h55555555, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = MEMOP_W; req_addr = 32'h20; req_wdata = 32'hAAAAAAAA;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmid.in_wait", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rmid.rv", {31'd0, resp_valid}, 32'd0);
        chk("rmid.rdy", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        txn("lw20", 1'b0, MEMOP_W, 32'h20, 32'h0, 32'h55555555, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
        txn("mis_lw22", 1'b0, MEMOP_W, 32'h22, 32'h0, 32'h0, 1'b1);
        txn("mis_sh21", 1'b1, MEMOP_H, 32'h21, 32'h0000FFFF, 32'h0, 1'b1);
        txn("mis_lw20", 1'b0, MEMOP_W, 32'h20, 32'h0, 32'h55555555, 1'b0);
`else
        txn("sw24",     1'b1, MEMOP_W, 32'h24, 32'hCAFE9ABC, 32'h0, 1'b0);
        txn("nomis_lh25", 1'b0, MEMOP_H, 32'h25, 32'h0, 32'hFFFF9ABC, 1'b0);
        txn("nomis_lw26", 1'b0, MEMOP_W, 32'h26, 32'h0, 32'hCAFE9ABC, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
